alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequences a single shared combinational ALU between two requesters, e.g. the integer pipeline (port 0) and a multi-cycle helper such as a branch/address unit (port 1). Each requester hands over operands and a 4-bit ALU opselect through a valid/ready handshake. The block registers the winning request onto the ALU inputs and captures the ALU result and flags one cycle later. It then returns them through a per-requester response handshake. Arbitration is round-robin, so neither requester can starve the other.

## Interface
Parameters:
- bus, 8, datapath width; must match the ALU instance.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending on port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle; combinational, at most one high.
- req0_a, req0_b / req1_a, req1_b  in  bus  operands.
- req0_op / req1_op  in  4  ALU opselect, passed through unmodified.
- rsp0_valid / rsp1_valid  out  1  response for port 0 / port 1 holds valid data.
- rsp0_ready / rsp1_ready  in  1  requester takes the response.
- rsp_result  out  bus  captured ALU result, shared by both ports and qualified by rspN_valid.
- rsp_zero, rsp_cout, rsp_overflow, rsp_negative  out  1 each  captured ALU flags.
- alu_a, alu_b  out  bus  registered operands to the ALU.
- alu_op  out  4  registered opselect to the ALU.
- alu_sout  in  bus  ALU result.
- alu_zero, alu_cout, alu_overflow, alu_negative  in  1 each  ALU flags.
- busy  out  1  high in every state other than IDLE.
- grant_id  out  1  owner of the operation in flight; meaningful only while busy.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE:**
  - If no request is valid, stay in IDLE.
  - If exactly one req is valid, grant it.
  - If both are valid, grant the port that was not granted last.
  - last_grant resets to 1, so port 0 wins the first tie.
  - On a grant: assert that port's reqN_ready combinationally for this cycle only.
  - On the same edge, load alu_a/alu_b/alu_op from the winner, load grant_id, update last_grant, and go to EXEC.
- **EXEC:**
  - alu_* are stable all cycle.
  - At the end of the cycle, capture alu_sout and the four flags into the rsp_* registers, set rsp{grant_id}_valid, and go to RESP.
  - No other action in EXEC.
- **RESP:**
  - Hold rsp_* and rspN_valid until rsp{grant_id}_ready is high.
  - On that edge, clear the valid and go to IDLE.
  - The non-owner's rspN_ready is ignored.
- reqN_ready is never asserted outside IDLE. A requester must hold its valid, operands and op stable until it sees ready.
- alu_a/alu_b/alu_op and rsp_* keep their last values between operations; they are not cleared on return to IDLE.
- The op field is never decoded. Flag semantics (which ops produce negative, cout or overflow) belong to the ALU and are forwarded verbatim.
- A request that drops its valid before being granted is simply not served; there is no error.

## Timing
- **Reset** (rst_n low, at any time including mid-operation) forces the following, asynchronously:
  - State: IDLE, last_grant=1.
  - Outputs: req0_ready=req1_ready=0 except the combinational grant in IDLE, rsp0_valid=rsp1_valid=0, busy=0, grant_id=0.
  - Data registers: rsp_result=0, all rsp flags=0, alu_a=alu_b=0, alu_op=4'b0000.
  - Any operation in flight is discarded with no response.
- Reset deassertion takes effect at the next clk edge. A valid request in the first cycle after release is grantable.
- **Latency:** accept at cycle T (reqN_ready=1), ALU evaluates in T+1, rspN_valid=1 from T+2.
  - If rspN_ready=1 at T+2, the block is back in IDLE at T+3, and the next accept can occur at T+3.
  - Peak throughput is therefore one operation per 3 cycles. Each cycle rspN_ready is held low adds one cycle.
- Combinational paths are limited to reqN_valid to reqN_ready, and alu_* in to the rsp_* register D-inputs. No path runs from alu_* in to any output in the same cycle.

## Test plan
Bench ALU model: op 0100 gives a+b; op 0101 gives a-b; zero = result==0; other flags are driven directly by the bench.
- Single add, bus=8: req0 a=8'h12, b=8'h34, op=0100 at T → req0_ready=1 at T; alu_a=12, alu_b=34 at T+1; rsp0_valid=1, rsp_result=8'h46, rsp_zero=0 at T+2; rsp1_valid stays 0.
- Tie after reset: both valid at T → port 0 granted at T. Port 1 stays valid, rsp0_ready=1 at T+2 → port 1 granted at T+3. Both valid again → port 0 granted next.
- Back-pressure: sub a=5, b=5 on port 1; rsp1_ready low for 4 cycles → rsp1_valid, rsp_result=0 and rsp_zero=1 held stable for all 4; req0_ready stays 0 throughout; IDLE is entered only after rsp1_ready goes high.
- Flag forwarding: bench drives alu_overflow=1, alu_negative=1 during EXEC → rsp_overflow=1, rsp_negative=1. Wrong-port rsp0_ready=1 while port 1 owns the response → no effect.
- Reset mid-op: assert rst_n=0 during EXEC → immediately busy=0, rsp*_valid=0, alu_op=0. After release, a new req0 is granted and completes normally.
- Random soak: 10k cycles with random valid/ready → every accepted request gets exactly one response with the model-correct result, in grant order. A persistently requesting port never waits more than one other operation.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Registers the winning request onto the ALU, captures result/flags, returns via per-port response handshake.
module alu_arbiter #(
  parameter int bus = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [bus-1:0] req0_a,
  input  logic [bus-1:0] req0_b,
  input  logic [3:0]     req0_op,
  input  logic [bus-1:0] req1_a,
  input  logic [bus-1:0] req1_b,
  input  logic [3:0]     req1_op,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  input  logic           rsp0_ready,
  input  logic           rsp1_ready,
  output logic [bus-1:0] rsp_result,
  output logic           rsp_zero,
  output logic           rsp_cout,
  output logic           rsp_overflow,
  output logic           rsp_negative,
  output logic [bus-1:0] alu_a,
  output logic [bus-1:0] alu_b,
  output logic [3:0]     alu_op,
  input  logic [bus-1:0] alu_sout,
  input  logic           alu_zero,
  input  logic           alu_cout,
  input  logic           alu_overflow,
  input  logic           alu_negative,
  output logic           busy,
  output logic           grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   rsp_taken;

  // On a tie the port that was not granted last wins; last_grant=1 favours port 0.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant))
        req0_ready = 1'b1;
      else if (req1_valid)
        req1_ready = 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign rsp_taken = grant_id ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_negative <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            alu_a      <= req1_ready ? req1_a  : req0_a;
            alu_b      <= req1_ready ? req1_b  : req0_b;
            alu_op     <= req1_ready ? req1_op : req0_op;
            grant_id   <= req1_ready;
            last_grant <= req1_ready;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= alu_sout;
          rsp_zero     <= alu_zero;
          rsp_cout     <= alu_cout;
          rsp_overflow <= alu_overflow;
          rsp_negative <= alu_negative;
          rsp0_valid   <= ~grant_id;
          rsp1_valid   <= grant_id;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random-soak bench for alu_arbiter with a behavioural ALU and an in-order scoreboard.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_cout, rsp_overflow, rsp_negative;
  logic [7:0] alu_a, alu_b, alu_sout;
  logic [3:0] alu_op;
  logic       alu_zero, alu_cout, alu_overflow, alu_negative;
  logic       busy, grant_id;

  typedef struct packed {
    logic       port;
    logic [7:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wait0   = 0;
  int   wait1   = 0;
  logic acc0, acc1;

  always #5 clk = ~clk;

  alu_arbiter #(.bus(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout),
    .rsp_overflow(rsp_overflow), .rsp_negative(rsp_negative),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sout(alu_sout), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'b0100: return a + b;
      4'b0101: return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_sout = model(alu_a, alu_b, alu_op);
  assign alu_zero = (alu_sout == 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      smp();
      if (!busy) done = 1;
    end
    if (!done) chk("wait_idle_timeout", 32'(busy), 32'd0);
    cyc();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    smp();
    smp();
    cyc();
    rst_n = 1'b1;
  endtask

  // Scoreboard and fairness monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      wait0 = 0;
      wait1 = 0;
    end else begin
      chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_valid && req0_ready) begin
        sb.push_back('{port: 1'b0, res: model(req0_a, req0_b, req0_op)});
        wait0 = 0;
        if (req1_valid) begin
          wait1++;
          chk("starve1", 32'(wait1 <= 1), 32'd1);
        end
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{port: 1'b1, res: model(req1_a, req1_b, req1_op)});
        wait1 = 0;
        if (req0_valid) begin
          wait0++;
          chk("starve0", 32'(wait0 <= 1), 32'd1);
        end
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_port", 32'(rsp1_valid), 32'(e.port));
          chk("sb_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
          chk("sb_result", 32'(rsp_result), 32'(e.res));
          chk("sb_zero", 32'(rsp_zero), 32'(e.res == 8'h00));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
    req0_op = '0;
    req1_op = '0;
    {alu_cout, alu_overflow, alu_negative} = '0;

    // Reset state
    smp();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_req_ready", 32'({req0_ready, req1_ready}), 0);
    cyc();
    rst_n = 1'b1;

    // Single add on port 0, issued in the first cycle after reset release
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 4'b0100;
    rsp0_ready = 1'b1;
    smp();
    chk("add_req0_ready", 32'(req0_ready), 1);
    chk("add_req1_ready", 32'(req1_ready), 0);
    cyc();
    req0_valid = 1'b0;
    smp();
    chk("add_alu_a", 32'(alu_a), 32'h12);
    chk("add_alu_b", 32'(alu_b), 32'h34);
    chk("add_alu_op", 32'(alu_op), 32'h4);
    chk("add_busy", 32'(busy), 1);
    chk("add_grant_id", 32'(grant_id), 0);
    cyc();
    smp();
    chk("add_rsp0_valid", 32'(rsp0_valid), 1);
    chk("add_rsp1_valid", 32'(rsp1_valid), 0);
    chk("add_result", 32'(rsp_result), 32'h46);
    chk("add_zero", 32'(rsp_zero), 0);
    cyc();
    smp();
    chk("add_back_idle", 32'(busy), 0);
    cyc();

    // Tie after reset
    reset_dut();
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 4'b0100;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h03; req1_op = 4'b0101;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b0;
    smp();
    chk("tie_req0_ready", 32'(req0_ready), 1);
    chk("tie_req1_ready", 32'(req1_ready), 0);
    cyc();
    req0_valid = 1'b0;
    smp();
    chk("tie_req1_wait_exec", 32'(req1_ready), 0);
    cyc();
    smp();
    chk("tie_rsp0_valid", 32'(rsp0_valid), 1);
    chk("tie_req1_wait_resp", 32'(req1_ready), 0);
    cyc();
    smp();
    chk("tie_req1_granted", 32'(req1_ready), 1);
    cyc();
    req1_valid = 1'b0;
    rsp1_ready = 1'b1;
    wait_idle();
    req0_valid = 1'b1; req0_a = 8'h20; req0_b = 8'h22; req0_op = 4'b0101;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_op = 4'b0100;
    smp();
    chk("tie2_req0_ready", 32'(req0_ready), 1);
    chk("tie2_req1_ready", 32'(req1_ready), 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // Back-pressure, flag forwarding and wrong-port ready on port 1
    req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h05; req1_op = 4'b0101;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    smp();
    chk("bp_req1_ready", 32'(req1_ready), 1);
    cyc();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h01; req0_op = 4'b0100;
    alu_overflow = 1'b1; alu_negative = 1'b1; alu_cout = 1'b0;
    smp();
    chk("bp_exec_busy", 32'(busy), 1);
    chk("bp_exec_req0_ready", 32'(req0_ready), 0);
    cyc();
    alu_overflow = 1'b0; alu_negative = 1'b0;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("bp_rsp1_valid", 32'(rsp1_valid), 1);
      chk("bp_rsp0_valid", 32'(rsp0_valid), 0);
      chk("bp_result", 32'(rsp_result), 0);
      chk("bp_zero", 32'(rsp_zero), 1);
      chk("bp_overflow", 32'(rsp_overflow), 1);
      chk("bp_negative", 32'(rsp_negative), 1);
      chk("bp_cout", 32'(rsp_cout), 0);
      chk("bp_req0_ready", 32'(req0_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      cyc();
    end
    rsp1_ready = 1'b1;
    smp();
    chk("bp_release_valid", 32'(rsp1_valid), 1);
    chk("bp_release_busy", 32'(busy), 1);
    cyc();
    smp();
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_req0_ready", 32'(req0_ready), 1);
    cyc();
    req0_valid = 1'b0;
    rsp1_ready = 1'b0;
    wait_idle();

    // Reset in the middle of an operation
    req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_op = 4'b0100;
    smp();
    chk("mid_req0_ready", 32'(req0_ready), 1);
    cyc();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rsp0_valid", 32'(rsp0_valid), 0);
    chk("mid_rsp1_valid", 32'(rsp1_valid), 0);
    chk("mid_alu_op", 32'(alu_op), 0);
    chk("mid_alu_a", 32'(alu_a), 0);
    chk("mid_rsp_result", 32'(rsp_result), 0);
    smp();
    cyc();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h20; req0_op = 4'b0100;
    smp();
    chk("post_rst_req0_ready", 32'(req0_ready), 1);
    cyc();
    req0_valid = 1'b0;
    smp();
    chk("post_rst_alu_a", 32'(alu_a), 32'hF0);
    cyc();
    wait_idle();

    // Random soak; requesters hold valid and operands until accepted
    for (int c = 0; c < 10000; c++) begin
      smp();
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      cyc();
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = 8'($urandom); req0_b = 8'($urandom);
        req0_op = 4'($urandom_range(0, 3) == 0 ? $urandom : 32'd4 + $urandom_range(0, 1));
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = 8'($urandom); req1_b = 8'($urandom);
        req1_op = 4'($urandom_range(0, 3) == 0 ? $urandom : 32'd4 + $urandom_range(0, 1));
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      {alu_cout, alu_overflow, alu_negative} = 3'($urandom);
    end

    // Drain: pending valids finish their handshakes, then everything must be answered
    for (int c = 0; c < 20; c++) begin
      smp();
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      cyc();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
    end
    smp();
    chk("drain_valids_low", 32'({req0_valid, req1_valid}), 0);
    chk("drain_sb_empty", 32'(sb.size()), 0);
    chk("drain_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
